ctrl_pipe: RTL and testbench

Carries decoded control words from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RV32I core. It sits between the opcode control decoder and the datapath stages. Each stage receives its control fields and destination register from here. The block also does load-use hazard detection, bubble injection, branch flush and EX-operand forwarding selection.

---
 rtl/rv_ctrl_pkg.sv | 58 +++++
 rtl/ctrl_pipe_forward_unit.sv | 29 ++
 rtl/ctrl_pipe.sv | 109 ++++++++++
 tb/tb_ctrl_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types for the RV32I pipeline control path: decoded control word,
// per-stage register layouts, forwarding select encoding and opcodes.
package rv_ctrl_pkg;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = 8'h00;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } idex_t;

  // Later stages carry only the control fields still consumed downstream.
  typedef struct packed {
    logic       valid;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [4:0] rd;
  } exmem_t;

  typedef struct packed {
    logic       valid;
    logic       memtoreg;
    logic       regwrite;
    logic [4:0] rd;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_forward_unit.sv
// EX-operand forwarding select; EX/MEM result wins over MEM/WB, x0 never forwards.
module forward_unit
  import rv_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  output fwd_sel_t   forward_a,
  output fwd_sel_t   forward_b
);

  function automatic fwd_sel_t select_src(input logic [4:0] rs);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign forward_a = select_src(ex_rs1);
  assign forward_b = select_src(ex_rs2);

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall,
// branch flush, global hold and forwarding selection.
module ctrl_pipe
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       id_valid,
  input  logic [7:0] id_ctrl,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_zero,
  output logic [7:0] ex_ctrl,
  output logic [4:0] ex_rs1,
  output logic [4:0] ex_rs2,
  output logic       mem_memread,
  output logic       mem_memwrite,
  output logic       mem_regwrite,
  output logic [4:0] mem_rd,
  output logic       wb_regwrite,
  output logic       wb_memtoreg,
  output logic [4:0] wb_rd,
  output logic       pc_stall,
  output logic       if_id_flush,
  output logic       branch_taken,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  idex_t    ex_q, ex_d;
  exmem_t   mem_q, mem_d;
  memwb_t   wb_q, wb_d;
  ctrl_t    id_ctrl_s;
  logic     take_branch;
  logic     load_use;
  fwd_sel_t fwd_a, fwd_b;

  assign id_ctrl_s = ctrl_t'(id_ctrl);

  // A held pipeline cannot redirect; the branch resolves once hold drops.
  assign take_branch = ~hold & ex_q.valid & ex_q.ctrl.branch & ex_zero;

  assign load_use = ex_q.valid & ex_q.ctrl.memread & (ex_q.rd != 5'd0) & id_valid &
                    ((ex_q.rd == id_rs1) | (id_uses_rs2 & (ex_q.rd == id_rs2)));

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d = '{valid: mem_q.valid, memtoreg: mem_q.memtoreg,
               regwrite: mem_q.regwrite, rd: mem_q.rd};
      mem_d = '{valid: ex_q.valid, memtoreg: ex_q.ctrl.memtoreg,
                regwrite: ex_q.ctrl.regwrite, memread: ex_q.ctrl.memread,
                memwrite: ex_q.ctrl.memwrite, rd: ex_q.rd};
      // id_ctrl is only sampled on a real instruction, so X never enters.
      if (take_branch || load_use || !id_valid) begin
        ex_d = IDEX_BUBBLE;
      end else begin
        ex_d = '{valid: 1'b1, ctrl: id_ctrl_s, rd: id_rd, rs1: id_rs1, rs2: id_rs2};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= IDEX_BUBBLE;
      mem_q <= EXMEM_BUBBLE;
      wb_q  <= MEMWB_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_ctrl      = ex_q.valid ? ex_q.ctrl : CTRL_NOP;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign mem_memread  = mem_q.valid & mem_q.memread;
  assign mem_memwrite = mem_q.valid & mem_q.memwrite;
  assign mem_regwrite = mem_q.valid & mem_q.regwrite;
  assign mem_rd       = mem_q.rd;
  assign wb_regwrite  = wb_q.valid & wb_q.regwrite;
  assign wb_memtoreg  = wb_q.valid & wb_q.memtoreg;
  assign wb_rd        = wb_q.rd;

  assign branch_taken = take_branch;
  assign if_id_flush  = take_branch;
  assign pc_stall     = hold | (load_use & ~take_branch);

  forward_unit u_fwd (
    .ex_rs1       (ex_q.rs1),
    .ex_rs2       (ex_q.rs2),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .forward_a    (fwd_a),
    .forward_b    (fwd_b)
  );

  assign forward_a = fwd_a;
  assign forward_b = fwd_b;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed and randomized checks of ctrl_pipe against an instruction-level pipeline model.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       id_valid = 1'b0;
  logic [7:0] id_ctrl = 8'h00;
  logic       id_uses_rs2 = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       ex_zero = 1'b0;

  logic [7:0] ex_ctrl;
  logic [4:0] ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       mem_memread, mem_memwrite, mem_regwrite;
  logic       wb_regwrite, wb_memtoreg;
  logic       pc_stall, if_id_flush, branch_taken;
  logic [1:0] forward_a, forward_b;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_zero(ex_zero), .ex_ctrl(ex_ctrl), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .pc_stall(pc_stall), .if_id_flush(if_id_flush), .branch_taken(branch_taken),
    .forward_a(forward_a), .forward_b(forward_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one record per in-flight instruction; slot 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    bit       v;
    bit [7:0] c;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
  } ins_t;

  ins_t pipe [3];

  function automatic bit m_taken();
    return !hold && pipe[0].v && pipe[0].c[2] && ex_zero;
  endfunction

  function automatic bit m_load_use();
    bit reads;
    reads = (pipe[0].rd == id_rs1) || (id_uses_rs2 && pipe[0].rd == id_rs2);
    return pipe[0].v && pipe[0].c[4] && pipe[0].rd != 0 && id_valid && reads;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (pipe[1].v && pipe[1].c[5] && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].v && pipe[2].c[5] && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_model();
    chk("ex_ctrl", ex_ctrl, pipe[0].v ? pipe[0].c : 8'h00);
    if (pipe[0].v) begin
      chk("ex_rs1", ex_rs1, pipe[0].rs1);
      chk("ex_rs2", ex_rs2, pipe[0].rs2);
      chk("forward_a", forward_a, m_fwd(pipe[0].rs1));
      chk("forward_b", forward_b, m_fwd(pipe[0].rs2));
    end
    chk("mem_memread", mem_memread, pipe[1].v & pipe[1].c[4]);
    chk("mem_memwrite", mem_memwrite, pipe[1].v & pipe[1].c[3]);
    chk("mem_regwrite", mem_regwrite, pipe[1].v & pipe[1].c[5]);
    chk("mem_rd", mem_rd, pipe[1].rd);
    chk("wb_regwrite", wb_regwrite, pipe[2].v & pipe[2].c[5]);
    chk("wb_memtoreg", wb_memtoreg, pipe[2].v & pipe[2].c[6]);
    chk("wb_rd", wb_rd, pipe[2].rd);
    chk("branch_taken", branch_taken, m_taken());
    chk("if_id_flush", if_id_flush, m_taken());
    chk("pc_stall", pc_stall, hold || (!m_taken() && m_load_use()));
  endtask

  task automatic clear_model();
    foreach (pipe[i]) pipe[i] = '0;
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    ins_t nxt [3];
    @(negedge clk);
    check_model();
    nxt = pipe;
    if (!rst_n) begin
      foreach (nxt[i]) nxt[i] = '0;
    end else if (!hold) begin
      nxt[2] = pipe[1];
      nxt[1] = pipe[0];
      if (id_valid && !m_taken() && !m_load_use())
        nxt[0] = '{v: 1'b1, c: id_ctrl, rd: id_rd, rs1: id_rs1, rs2: id_rs2};
      else
        nxt[0] = '0;
    end
    @(posedge clk);
    #1;
    pipe = nxt;
  endtask

  task automatic drv(input bit v, input logic [7:0] c, input bit u2,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid    = v;
    id_ctrl     = v ? c : 8'bx;
    id_uses_rs2 = u2;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
  endtask

  logic [7:0] ctrl_tbl [6];

  initial begin
    ctrl_tbl[0] = 8'hF0;  // load
    ctrl_tbl[1] = 8'h22;  // R-type
    ctrl_tbl[2] = 8'hA0;  // OP-IMM
    ctrl_tbl[3] = 8'h05;  // branch
    ctrl_tbl[4] = 8'h88;  // store
    ctrl_tbl[5] = 8'h15;  // load + branch bits together
    clear_model();

    #1;
    chk("reset_ex_ctrl", ex_ctrl, 8'h00);
    chk("reset_wb_regwrite", wb_regwrite, 0);
    chk("reset_fwd", {forward_a, forward_b}, 4'b0000);
    chk("reset_stall", pc_stall, 0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Latency: ID -> EX +1, MEM +2, WB +3
    drv(1, 8'hA0, 0, 5'd1, 5'd0, 5'd9); cycle();
    drv(0, 8'h00, 0, 0, 0, 0); #1 chk("lat_ex", ex_ctrl, 8'hA0); cycle();
    #1 chk("lat_mem_rw", mem_regwrite, 1); chk("lat_mem_rd", mem_rd, 9); cycle();
    #1 chk("lat_wb_rw", wb_regwrite, 1); chk("lat_wb_rd", wb_rd, 9); cycle();

    // Load-use: lw x5 then add x6,x5,x7
    drv(1, 8'hF0, 0, 5'd1, 5'd0, 5'd5); cycle();
    drv(1, 8'h22, 1, 5'd5, 5'd7, 5'd6); #1 chk("lu_stall", pc_stall, 1); cycle();
    #1 chk("lu_bubble", ex_ctrl, 8'h00); chk("lu_stall_once", pc_stall, 0); cycle();
    drv(0, 8'h00, 0, 0, 0, 0);
    #1 chk("lu_fwd_a", forward_a, 2'b01); chk("lu_fwd_b", forward_b, 2'b00); cycle();

    // No false hazard: x0 destination, unused rs2 field
    drv(1, 8'hF0, 0, 5'd1, 5'd0, 5'd0); cycle();
    drv(1, 8'h22, 1, 5'd0, 5'd0, 5'd6); #1 chk("nf_x0", pc_stall, 0); cycle();
    drv(1, 8'hF0, 0, 5'd1, 5'd0, 5'd5); cycle();
    drv(1, 8'hA0, 0, 5'd1, 5'd5, 5'd8); #1 chk("nf_rs2", pc_stall, 0); cycle();
    drv(0, 8'h00, 0, 0, 0, 0); cycle();

    // Taken branch
    drv(1, 8'h05, 1, 5'd1, 5'd2, 5'd0); cycle();
    ex_zero = 1'b1; drv(1, 8'h22, 1, 5'd3, 5'd4, 5'd7);
    #1 chk("br_taken", branch_taken, 1); chk("br_flush", if_id_flush, 1);
    chk("br_stall", pc_stall, 0); cycle();
    ex_zero = 1'b0; drv(0, 8'h00, 0, 0, 0, 0);
    #1 chk("br_bubble", ex_ctrl, 8'h00); cycle();

    // Taken branch with simultaneous load-use: flush wins
    drv(1, 8'h15, 1, 5'd1, 5'd2, 5'd5); cycle();
    ex_zero = 1'b1; drv(1, 8'h22, 1, 5'd5, 5'd4, 5'd7);
    #1 chk("bl_stall", pc_stall, 0); chk("bl_taken", branch_taken, 1); cycle();
    ex_zero = 1'b0; drv(0, 8'h00, 0, 0, 0, 0); cycle();

    // Forward priority: MEM beats WB
    drv(1, 8'h22, 1, 5'd1, 5'd2, 5'd3); cycle();
    cycle();
    drv(1, 8'h22, 1, 5'd3, 5'd3, 5'd4); cycle();
    drv(0, 8'h00, 0, 0, 0, 0);
    #1 chk("fp_a", forward_a, 2'b10); chk("fp_b", forward_b, 2'b10); cycle();
    drv(1, 8'h22, 1, 5'd1, 5'd2, 5'd0); cycle();
    cycle();
    drv(1, 8'h22, 1, 5'd0, 5'd0, 5'd4); cycle();
    drv(0, 8'h00, 0, 0, 0, 0);
    #1 chk("fz_a", forward_a, 2'b00); chk("fz_b", forward_b, 2'b00); cycle();

    // Hold with a taken branch in EX
    drv(1, 8'h05, 1, 5'd1, 5'd2, 5'd0); cycle();
    ex_zero = 1'b1; hold = 1'b1; drv(1, 8'h22, 1, 5'd3, 5'd4, 5'd7);
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_bt", branch_taken, 0); chk("hold_stall", pc_stall, 1);
      chk("hold_ex", ex_ctrl, 8'h05);
      cycle();
    end
    hold = 1'b0;
    #1 chk("hold_release_bt", branch_taken, 1); cycle();
    ex_zero = 1'b0; drv(0, 8'h00, 0, 0, 0, 0); cycle();

    // Asynchronous reset with a full pipeline
    drv(1, 8'h22, 1, 5'd1, 5'd2, 5'd3); cycle(); cycle(); cycle();
    #2 rst_n = 1'b0;
    #1 chk("arst_ex", ex_ctrl, 8'h00); chk("arst_mem", mem_regwrite, 0);
    chk("arst_wb", wb_regwrite, 0); chk("arst_wb_rd", wb_rd, 0); chk("arst_stall", pc_stall, 0);
    clear_model();
    drv(0, 8'h00, 0, 0, 0, 0); cycle();
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if (!rst_n) clear_model();
      hold    = ($urandom_range(0, 9) == 0);
      ex_zero = $urandom_range(0, 1);
      drv($urandom_range(0, 3) != 0, ctrl_tbl[$urandom_range(0, 5)], $urandom_range(0, 1),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
